// File: rtl/xbar_rr_arbiter_pkg.sv
// Shared crossbar configuration: default port count, mux select width and
// arbiter state encodings, read by the output-port mux and xbar_rr_arbiter.
package xbar_rr_arbiter_pkg;

  localparam int XBAR_N  = 4;
  localparam int XBAR_SW = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xbar_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping
// from N-1 back to 0. found is low when no request is present.
module xbar_rr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] winner,
  output logic          found
);

  // rot[k] is the request of index (ptr + k) mod N.
  logic [N-1:0] rot;
  logic [SW:0]  sum;

  assign rot = N'({req, req} >> ptr);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int off = 0; off < N; off++) begin
      if (!found && rot[off]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (SW+1)'(off);
        if (sum >= (SW+1)'(N)) begin
          sum = sum - (SW+1)'(N);
        end
        winner = sum[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter for one crossbar output port: registered one-hot grant
// plus binary mux select. Optional forced release under XBAR_ARB_TIMEOUT_EN.
module xbar_rr_arbiter
  import xbar_rr_arbiter_pkg::*;
#(
  parameter int N        = XBAR_N,
  parameter int SW       = XBAR_SW,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] sel,
  output logic          gnt_vld,
  output logic          timeout
);

  // Handshake: a requester raises req[i] and holds it for its whole transfer;
  // gnt[i]/sel become valid one edge later and stay until req[i] drops (or a
  // forced release); the edge that samples req[i]=0 ends the grant.

  localparam int              SELW = 1 << SW;
  localparam logic [SW-1:0]   LAST = SW'(N - 1);

  if (N < 2 || N > SELW || MAX_HOLD < 2) begin : g_bad_cfg
    $error("xbar_rr_arbiter: invalid N/SW/MAX_HOLD combination");
  end

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
`endif

  // Control state kept together so checkers can bind to a single struct.
  typedef struct packed {
    arb_state_e    state;
    logic [SW-1:0] ptr;
`ifdef XBAR_ARB_TIMEOUT_EN
    logic [HW-1:0] hold_cnt;
`endif
  } arb_ctl_t;

  arb_ctl_t        ctl_q, ctl_d;
  logic [N-1:0]    gnt_d;
  logic [SW-1:0]   sel_d;
  logic [SW-1:0]   ptr_adv;
  logic [SW-1:0]   pick_ptr;
  logic [SW-1:0]   win;
  logic            found;
  logic [SELW-1:0] req_ext;
  logic            req_own;
  logic            forced;
  logic            release_now;
`ifdef XBAR_ARB_TIMEOUT_EN
  logic            timeout_d;
`endif

  assign req_ext = SELW'(req);
  assign req_own = req_ext[sel];
  assign ptr_adv = (sel == LAST) ? '0 : sel + 1'b1;

  // During a grant the pick already uses the advanced pointer, so a releasing
  // owner that still requests (forced release) ends up at lowest priority.
  assign pick_ptr = (ctl_q.state == ARB_GRANT) ? ptr_adv : ctl_q.ptr;

`ifdef XBAR_ARB_TIMEOUT_EN
  assign forced = req_own && (ctl_q.hold_cnt == HW'(MAX_HOLD - 1));
`else
  assign forced = 1'b0;
`endif

  assign release_now = !req_own || forced;

  xbar_rr_arbiter_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (win),
    .found  (found)
  );

  always_comb begin
    ctl_d = ctl_q;
    gnt_d = gnt;
    sel_d = sel;
`ifdef XBAR_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (ctl_q.state)
      ARB_IDLE: begin
        if (en && found) begin
          ctl_d.state = ARB_GRANT;
          gnt_d       = N'(1) << win;
          sel_d       = win;
        end
      end
      ARB_GRANT: begin
        if (release_now) begin
          ctl_d.ptr = ptr_adv;
`ifdef XBAR_ARB_TIMEOUT_EN
          ctl_d.hold_cnt = '0;
          timeout_d      = forced;
`endif
          if (en && found) begin
            gnt_d = N'(1) << win;
            sel_d = win;
          end else begin
            ctl_d.state = ARB_IDLE;
            gnt_d       = '0;
          end
        end else begin
`ifdef XBAR_ARB_TIMEOUT_EN
          if (ctl_q.hold_cnt != HW'(MAX_HOLD - 1)) begin
            ctl_d.hold_cnt = ctl_q.hold_cnt + 1'b1;
          end
`endif
        end
      end
      default: begin
        ctl_d.state = ARB_IDLE;
        gnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q.state <= ARB_IDLE;
      ctl_q.ptr   <= '0;
`ifdef XBAR_ARB_TIMEOUT_EN
      ctl_q.hold_cnt <= '0;
`endif
      gnt <= '0;
      sel <= '0;
    end else begin
      ctl_q <= ctl_d;
      gnt   <= gnt_d;
      sel   <= sel_d;
    end
  end

`ifdef XBAR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign gnt_vld = |gnt;

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Bench for xbar_rr_arbiter: scenario tasks plus randomized traffic checked
// cycle by cycle against an owner/pointer model of the round-robin rules.
module tb_xbar_rr_arbiter;

  localparam int N        = 4;
  localparam int SW       = 2;
  localparam int MAX_HOLD = 16;
  localparam int W        = 8;
`ifdef XBAR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [SW-1:0] sel;
  logic          gnt_vld;
  logic          timeout;

  always #5 clk = ~clk;

  xbar_rr_arbiter #(
    .N        (N),
    .SW       (SW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // Model: who owns the port (-1 = nobody), where the next search starts,
  // the last granted index, and how many cycles the grant has been visible.
  int m_owner, m_rr, m_sel, m_held;
  bit m_to;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_sel = 0; m_held = 0; m_to = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic e);
    bit frc;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      frc = TO_EN && r[m_owner] && (m_held == MAX_HOLD);
      if (!r[m_owner] || frc) begin
        m_rr    = (m_owner + 1) % N;
        m_to    = frc;
        m_owner = -1;
        m_held  = 0;
      end else if (m_held < MAX_HOLD) begin
        m_held++;
      end
    end
    if (m_owner < 0 && e && r != '0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_rr + k) % N]) begin
          m_owner = (m_rr + k) % N;
          m_sel   = m_owner;
          m_held  = 1;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] model_exp();
    logic [N-1:0]  g;
    logic [SW-1:0] s;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    s = SW'(m_sel);
    return {m_to, (m_owner >= 0), s, g};
  endfunction

  // One clock: model consumes the same inputs the DUT samples at this edge.
  task automatic tick();
    model_step(req, en);
    exp_q.push_back(model_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [W-1:0] got, exp;
    rst_n = 1'b0; req = '0; en = 1'b0;
    #2;
    got = {timeout, gnt_vld, sel, gnt};
    n_cmp++;
    if (got !== 8'h00) begin
      n_fail++; $display("FAIL reset_initial: got %b want %b", got, 8'h00);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    en = 1'b1; req = 4'b0010;
    tick();
    got = {timeout, gnt_vld, sel, gnt}; exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL reset_pregrant: got %b want %b", got, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {timeout, gnt_vld, sel, gnt};
    n_cmp++;
    if (got !== 8'h00) begin
      n_fail++; $display("FAIL reset_midgrant: got %b want %b", got, 8'h00);
    end
    req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    logic [W-1:0] got, exp;
    en = 1'b1; req = 4'b0100;
    tick();
    got = {timeout, gnt_vld, sel, gnt}; exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || gnt !== 4'b0100 || sel !== 2'd2) begin
      n_fail++; $display("FAIL single_grant: got %b want %b", got, exp);
    end
    req = 4'b0000;
    tick();
    got = {timeout, gnt_vld, sel, gnt}; exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || gnt !== 4'b0000 || sel !== 2'd2) begin
      n_fail++; $display("FAIL single_release: got %b want %b", got, exp);
    end
  endtask

  task automatic test_fairness();
    logic [W-1:0] got, exp;
    logic [N-1:0] r, prev;
    logic [N-1:0] order[$];
    logic [N-1:0] want[5];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    en = 1'b1; prev = '0;
    for (int c = 0; c < 15; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b0;
      req = r;
      tick();
      got = {timeout, gnt_vld, sel, gnt}; exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL fairness_cycle%0d: got %b want %b", c, got, exp);
      end
      if (gnt !== prev && gnt !== '0) order.push_back(gnt);
      prev = gnt;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (i >= order.size() || order[i] !== want[i]) begin
        n_fail++;
        $display("FAIL fairness_order%0d: got %b want %b", i,
                 (i < order.size()) ? order[i] : 4'bxxxx, want[i]);
      end
    end
  endtask

  task automatic test_handoff();
    logic [W-1:0] got, exp;
    logic [N-1:0] stim[4];
    stim = '{4'b0000, 4'b1000, 4'b0011, 4'b0010};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req = stim[i];
      tick();
      got = {timeout, gnt_vld, sel, gnt}; exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL handoff_step%0d: got %b want %b", i, got, exp);
      end
      if (i == 2) begin
        n_cmp++;
        if (gnt !== 4'b0001) begin
          n_fail++; $display("FAIL handoff_wrap: got %b want %b", gnt, 4'b0001);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] got, exp;
    logic [N-1:0] stim[16];
    logic         ens[16];
    req = '0; en = 1'b1;
    tick();
    void'(exp_q.pop_front());
    for (int i = 0; i < 16; i++) begin
      stim[i] = 4'b0001; ens[i] = 1'b0;
    end
    ens[10] = 1'b1;
    stim[11] = 4'b0011; stim[12] = 4'b0011; stim[13] = 4'b0010;
    stim[14] = 4'b0010; stim[15] = 4'b0010; ens[15] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req = stim[i]; en = ens[i];
      tick();
      got = {timeout, gnt_vld, sel, gnt}; exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL enable_step%0d: got %b want %b", i, got, exp);
      end
      if (i == 13) begin
        n_cmp++;
        if (gnt !== 4'b0000) begin
          n_fail++; $display("FAIL enable_idle: got %b want %b", gnt, 4'b0000);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] got, exp;
    do_reset();
    en = 1'b1; req = 4'b0101;
    for (int c = 1; c <= 100; c++) begin
      tick();
      got = {timeout, gnt_vld, sel, gnt}; exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL timeout_cycle%0d: got %b want %b", c, got, exp);
      end
`ifdef XBAR_ARB_TIMEOUT_EN
      if (c == 17) begin
        n_cmp++;
        if (gnt !== 4'b0100 || timeout !== 1'b1) begin
          n_fail++; $display("FAIL timeout_force: got gnt=%b to=%b want 0100/1", gnt, timeout);
        end
      end
`else
      if (c == 100) begin
        n_cmp++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
          n_fail++; $display("FAIL timeout_off: got gnt=%b to=%b want 0001/0", gnt, timeout);
        end
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [W-1:0] got, exp;
    logic [N-1:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      req = r;
      en  = ($urandom_range(0, 9) != 0);
      tick();
      got = {timeout, gnt_vld, sel, gnt}; exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || $countones(gnt) > 1) begin
        n_fail++; $display("FAIL random_cycle%0d: got %b want %b", c, got, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; en = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_handoff();
    test_enable();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
